// File: rtl/dwr_pkg.sv
// Shared definitions for the die wrapper register and its test sequencer:
// 1149.1 TAP state codes, wrapper instruction codes and the command opcode.
package dwr_pkg;

  localparam logic [3:0] TAP_RTI        = 4'b1100;
  localparam logic [3:0] TAP_SELECT_DR  = 4'b0111;
  localparam logic [3:0] TAP_CAPTURE_DR = 4'b0110;
  localparam logic [3:0] TAP_SHIFT_DR   = 4'b0010;
  localparam logic [3:0] TAP_EXIT1_DR   = 4'b0001;
  localparam logic [3:0] TAP_UPDATE_DR  = 4'b0101;

  localparam logic [3:0] IR_EXTEST = 4'b0000;
  localparam logic [3:0] IR_INTEST = 4'b0010;
  localparam logic [3:0] IR_SAMPLE = 4'b0100;
  localparam logic [3:0] IR_BYPASS = 4'b1111;

  typedef enum logic [1:0] {
    OP_EXTEST  = 2'b00,
    OP_INTEST  = 2'b01,
    OP_SAMPLE  = 2'b10,
    OP_ILLEGAL = 2'b11
  } cmd_op_e;

  // Instruction the wrapper must hold for a given command; BYPASS for the
  // illegal opcode so a stray lookup never selects a real register.
  function automatic logic [3:0] ir_for_op(input logic [1:0] op);
    case (cmd_op_e'(op))
      OP_EXTEST: ir_for_op = IR_EXTEST;
      OP_INTEST: ir_for_op = IR_INTEST;
      OP_SAMPLE: ir_for_op = IR_SAMPLE;
      default:   ir_for_op = IR_BYPASS;
    endcase
  endfunction

  function automatic logic op_is_legal(input logic [1:0] op);
    op_is_legal = (cmd_op_e'(op) != OP_ILLEGAL);
  endfunction

endpackage

// File: rtl/dwr_shift_counter.sv
// Loadable up-counter tracking the bit position inside a SHIFT_DR run.
// tc flags the last bit (WIDTH-1) so the FSM can leave SHIFT on time.
module dwr_shift_counter
  import dwr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             TCK,
  input  logic             TRST_N,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  logic [CNT_W-1:0] count_reg;

  // Load has priority over counting; reset returns to bit 0.
  always_ff @(posedge TCK) begin
    if (!TRST_N) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign count = count_reg;
  assign tc    = (count_reg == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/dwr_test_sequencer.sv
// Command-driven DWR sequencer: each accepted command walks the DR branch
// Select->Capture->Shift(WIDTH)->Exit1->Update and returns the captured bits.
// Accept spends one launch cycle in IDLE (ir already loaded, tap still RTI)
// so the first TAP state appears one edge after the accept edge.
module dwr_test_sequencer
  import dwr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             TCK,
  input  logic             TRST_N,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [3:0]       tap_state,
  output logic [3:0]       ir,
  output logic             dwr_tdi,
  input  logic             dwr_tdo,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_CAP, S_SHIFT, S_EXIT1, S_UPD, S_RESP
  } seq_state_e;

  function automatic logic [3:0] tap_code(input seq_state_e s);
    case (s)
      S_SEL:   tap_code = TAP_SELECT_DR;
      S_CAP:   tap_code = TAP_CAPTURE_DR;
      S_SHIFT: tap_code = TAP_SHIFT_DR;
      S_EXIT1: tap_code = TAP_EXIT1_DR;
      S_UPD:   tap_code = TAP_UPDATE_DR;
      default: tap_code = TAP_RTI;
    endcase
  endfunction

  seq_state_e       state_reg, state_next;
  logic             launch_reg, launch_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [WIDTH-1:0] rsp_data_reg, rsp_data_next;
  logic             rsp_err_reg, rsp_err_next;
  logic [3:0]       ir_reg, ir_next;
  logic [3:0]       tap_reg;
  logic             cnt_load, cnt_en, cnt_tc;
  logic [CNT_W-1:0] cnt_q;

  dwr_shift_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_shift_counter (
    .TCK      (TCK),
    .TRST_N   (TRST_N),
    .load     (cnt_load),
    .load_val ({CNT_W{1'b0}}),
    .en       (cnt_en),
    .count    (cnt_q),
    .tc       (cnt_tc)
  );

  // Next-state, command latching, response capture and counter control.
  always_comb begin
    state_next    = state_reg;
    launch_next   = 1'b0;
    data_next     = data_reg;
    rsp_data_next = rsp_data_reg;
    rsp_err_next  = rsp_err_reg;
    ir_next       = ir_reg;
    cnt_load      = 1'b0;
    cnt_en        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (launch_reg) begin
          state_next = S_SEL;
        end else if (cmd_valid) begin
          data_next     = cmd_data;
          rsp_data_next = '0;
          if (op_is_legal(cmd_op)) begin
            rsp_err_next = 1'b0;
            ir_next      = ir_for_op(cmd_op);
            launch_next  = 1'b1;
          end else begin
            rsp_err_next = 1'b1;
            state_next   = S_RESP;
          end
        end
      end
      S_SEL: state_next = S_CAP;
      S_CAP: begin
        cnt_load   = 1'b1;
        state_next = S_SHIFT;
      end
      S_SHIFT: begin
        cnt_en               = 1'b1;
        rsp_data_next[cnt_q] = dwr_tdo;
        if (cnt_tc) begin
          state_next = S_EXIT1;
        end
      end
      S_EXIT1: state_next = S_UPD;
      S_UPD: begin
        // ir stays valid through the update cycle, drops as RESP begins
        ir_next    = IR_BYPASS;
        state_next = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_err_next = 1'b0;
          state_next   = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State and output registers; tap_state tracks the state being entered.
  always_ff @(posedge TCK) begin
    if (!TRST_N) begin
      state_reg    <= S_IDLE;
      launch_reg   <= 1'b0;
      data_reg     <= '0;
      rsp_data_reg <= '0;
      rsp_err_reg  <= 1'b0;
      ir_reg       <= IR_BYPASS;
      tap_reg      <= TAP_RTI;
    end else begin
      state_reg    <= state_next;
      launch_reg   <= launch_next;
      data_reg     <= data_next;
      rsp_data_reg <= rsp_data_next;
      rsp_err_reg  <= rsp_err_next;
      ir_reg       <= ir_next;
      tap_reg      <= tap_code(state_next);
    end
  end

  assign cmd_ready = (state_reg == S_IDLE) && !launch_reg;
  assign busy      = !cmd_ready;
  assign rsp_valid = (state_reg == S_RESP);
  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = rsp_err_reg;
  assign tap_state = tap_reg;
  assign ir        = ir_reg;
  assign dwr_tdi   = (state_reg == S_SHIFT) ? data_reg[cnt_q] : 1'b0;

endmodule

// File: tb/tb_dwr_test_sequencer.sv
// Bench for dwr_test_sequencer driving a behavioural 8-bit DWR.
module tb_dwr_test_sequencer;
  import dwr_pkg::*;

  localparam int W = 8;

  logic         TCK = 1'b0;
  logic         TRST_N;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_err;
  logic [3:0]   tap_state;
  logic [3:0]   ir;
  logic         dwr_tdi;
  logic         dwr_tdo;
  logic         busy;

  int n_cmp  = 0;
  int n_fail = 0;

  dwr_test_sequencer #(.WIDTH(W)) dut (
    .TCK       (TCK),
    .TRST_N    (TRST_N),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .tap_state (tap_state),
    .ir        (ir),
    .dwr_tdi   (dwr_tdi),
    .dwr_tdo   (dwr_tdo),
    .busy      (busy)
  );

  always #5 TCK = ~TCK;

  // Behavioural DWR: captures func_in, shifts toward bit 0, commits on update.
  logic [W-1:0] func_in = 8'h3C;
  logic [W-1:0] dwr_sr = '0;
  logic [W-1:0] wrapper_out = '0;
  int           update_cnt = 0;

  always @(posedge TCK) begin
    case (tap_state)
      TAP_CAPTURE_DR: dwr_sr <= func_in;
      TAP_SHIFT_DR:   dwr_sr <= {dwr_tdi, dwr_sr[W-1:1]};
      TAP_UPDATE_DR: begin
        update_cnt <= update_cnt + 1;
        if (ir == IR_EXTEST || ir == IR_INTEST) wrapper_out <= dwr_sr;
      end
      default: ;
    endcase
  end
  assign dwr_tdo = dwr_sr[0];

  logic [3:0] tap_log[$];

  task automatic step();
    @(posedge TCK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected tap_state after edge Ei of a legal command (i >= 1).
  function automatic logic [3:0] exp_tap(input int i);
    if (i == 1)          return TAP_SELECT_DR;
    else if (i == 2)     return TAP_CAPTURE_DR;
    else if (i <= W + 2) return TAP_SHIFT_DR;
    else if (i == W + 3) return TAP_EXIT1_DR;
    else if (i == W + 4) return TAP_UPDATE_DR;
    else                 return TAP_RTI;
  endfunction

  // One full command with response handshake; prints one transaction line.
  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [7:0] data,
                        input logic [7:0] func, input int hold, input bit stray,
                        input logic [7:0] exp_data, input logic exp_err,
                        input int exp_lat, input logic [7:0] exp_wrap);
    int          w;
    int          lat;
    int          busy_bad;
    int          hold_bad;
    logic [7:0]  rdata;
    logic        rerr;
    w = 0;
    while (!cmd_ready && w < 50) begin
      step();
      w++;
    end
    check({tag, ".ready_wait"}, 32'(cmd_ready), 32'd1);
    func_in   = func;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    rsp_ready = (hold == 0);
    step();
    cmd_valid = 1'b0;
    tap_log.delete();
    lat      = 0;
    busy_bad = 0;
    while (!rsp_valid && lat < 40) begin
      if (cmd_ready || !busy) busy_bad++;
      step();
      lat++;
      tap_log.push_back(tap_state);
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".busy_ready"}, 32'(busy_bad), 32'd0);
    if (exp_lat > 0) begin
      check({tag, ".tap_len"}, 32'(tap_log.size()), 32'(exp_lat));
      for (int i = 0; i < tap_log.size(); i++)
        check($sformatf("%s.tap[%0d]", tag, i + 1), 32'(tap_log[i]), 32'(exp_tap(i + 1)));
    end
    rdata = rsp_data;
    rerr  = rsp_err;
    check({tag, ".rsp_data"}, 32'(rdata), 32'(exp_data));
    check({tag, ".rsp_err"}, 32'(rerr), 32'(exp_err));
    check({tag, ".resp_tap_ir"}, {24'd0, tap_state, ir}, {24'd0, TAP_RTI, IR_BYPASS});
    if (hold > 0) begin
      hold_bad = 0;
      if (stray) begin
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_data  = 8'hF0;
      end
      for (int h = 0; h < hold; h++) begin
        step();
        if (!rsp_valid || rsp_data !== rdata || rsp_err !== rerr ||
            tap_state !== TAP_RTI || cmd_ready) hold_bad++;
      end
      check({tag, ".hold_stable"}, 32'(hold_bad), 32'd0);
      rsp_ready = 1'b1;
    end
    step();
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    check({tag, ".after_hs"}, {30'd0, rsp_valid, cmd_ready}, {30'd0, 1'b0, 1'b1});
    check({tag, ".wrapper_out"}, 32'(wrapper_out), 32'(exp_wrap));
    $display("txn %s op=%0d data=%02h func=%02h hold=%0d -> rsp=%02h err=%0d lat=%0d wrap=%02h",
             tag, op, data, func, hold, rdata, rerr, lat, wrapper_out);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic [7:0] func;
    int         hold;
    bit         stray;
    logic [7:0] exp_data;
    logic       exp_err;
    int         exp_lat;
    logic [7:0] exp_wrap;
  } vec_t;

  vec_t vecs[6];

  initial begin
    automatic logic [7:0] model_wrap;
    automatic int         upd_snap;
    automatic logic [7:0] wrap_snap;
    automatic int         w;
    automatic int         bad;

    vecs[0] = '{2'b01, 8'hA5, 8'h3C, 0, 1'b0, 8'h3C, 1'b0, W + 5, 8'hA5};
    vecs[1] = '{2'b10, 8'hFF, 8'h3C, 0, 1'b0, 8'h3C, 1'b0, W + 5, 8'hA5};
    vecs[2] = '{2'b00, 8'h0F, 8'h3C, 4, 1'b1, 8'h3C, 1'b0, W + 5, 8'h0F};
    vecs[3] = '{2'b00, 8'hF0, 8'h3C, 0, 1'b0, 8'h3C, 1'b0, W + 5, 8'hF0};
    vecs[4] = '{2'b11, 8'h77, 8'h3C, 2, 1'b0, 8'h00, 1'b1, 0,     8'hF0};
    vecs[5] = '{2'b01, 8'h00, 8'hC3, 1, 1'b0, 8'hC3, 1'b0, W + 5, 8'h00};

    TRST_N    = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    repeat (3) step();
    TRST_N = 1'b1;

    // Idle after reset: nothing moves.
    for (int c = 0; c < 5; c++) begin
      check($sformatf("idle%0d.tap", c), 32'(tap_state), 32'(TAP_RTI));
      check($sformatf("idle%0d.ir", c), 32'(ir), 32'(IR_BYPASS));
      check($sformatf("idle%0d.ctl", c), {27'd0, cmd_ready, rsp_valid, busy, dwr_tdi, rsp_err},
            {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      check($sformatf("idle%0d.rsp_data", c), 32'(rsp_data), 32'd0);
      step();
    end

    for (int v = 0; v < 6; v++)
      do_cmd($sformatf("vec%0d", v), vecs[v].op, vecs[v].data, vecs[v].func, vecs[v].hold,
             vecs[v].stray, vecs[v].exp_data, vecs[v].exp_err, vecs[v].exp_lat, vecs[v].exp_wrap);
    model_wrap = vecs[5].exp_wrap;

    // Reset during the 4th SHIFT_DR cycle of INTEST 8'h55.
    upd_snap  = update_cnt;
    wrap_snap = wrapper_out;
    func_in   = 8'h3C;
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_data  = 8'h55;
    step();
    cmd_valid = 1'b0;
    w = 0;
    while (tap_state != TAP_SHIFT_DR && w < 20) begin
      step();
      w++;
    end
    check("rst.reach_shift", 32'(tap_state), 32'(TAP_SHIFT_DR));
    repeat (3) step();
    TRST_N = 1'b0;
    step();
    check("rst.tap", 32'(tap_state), 32'(TAP_RTI));
    check("rst.ir", 32'(ir), 32'(IR_BYPASS));
    check("rst.ctl", {29'd0, busy, rsp_valid, dwr_tdi}, 32'd0);
    TRST_N = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (rsp_valid || tap_state != TAP_RTI || !cmd_ready) bad++;
    end
    check("rst.quiet", 32'(bad), 32'd0);
    check("rst.no_update", 32'(update_cnt - upd_snap), 32'd0);
    check("rst.wrapper", 32'(wrapper_out), 32'(wrap_snap));
    $display("txn rst_mid_shift wrap=%02h updates=%0d", wrapper_out, update_cnt - upd_snap);

    // Randomised commands against the reference model.
    for (int r = 0; r < 24; r++) begin
      automatic logic [1:0] op   = 2'($urandom_range(0, 3));
      automatic logic [7:0] data = 8'($urandom);
      automatic logic [7:0] func = 8'($urandom);
      automatic int         hold = int'($urandom_range(0, 3));
      automatic logic [7:0] e_data;
      automatic int         e_lat;
      if (op == 2'b11) begin
        e_data = 8'h00;
        e_lat  = 0;
      end else begin
        e_data = func;
        e_lat  = W + 5;
      end
      if (op == 2'b00 || op == 2'b01) model_wrap = data;
      do_cmd($sformatf("rnd%0d", r), op, data, func, hold, 1'b0,
             e_data, (op == 2'b11), e_lat, model_wrap);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dwr_test_sequencer.md
# dwr_test_sequencer

Command-driven sequencer that runs complete boundary-scan data-register operations on the die wrapper register (DWR) without an external TAP. It drives the DWR's `tap_state`, `IR` and `TDI` inputs and collects its `wrapper_tdo`. It sits between an on-die test agent, such as the BIST or debug master, and the DWR. Each accepted command produces a full Select→Capture→Shift→Exit1→Update walk and returns the captured wrapper contents.

## Interface
Parameters:
- `WIDTH`, default 8: DWR chain length in bits. Must match the DWR.
- `CNT_W`, default `$clog2(WIDTH)`: width of the shift counter.

Ports:
- `TCK`  in  1  clock; all state updates on rising edge.
- `TRST_N`  in  1  reset; synchronous, active-low.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  controller can accept a command. High only in IDLE.
- `cmd_op`  in  2  operation: 00 EXTEST, 01 INTEST, 10 SAMPLE, 11 illegal.
- `cmd_data`  in  WIDTH  pattern to shift into the DWR, LSB first.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed.
- `rsp_data`  out  WIDTH  bits shifted out of the DWR; bit k is the k-th bit out.
- `rsp_err`  out  1  response belongs to an illegal op.
- `tap_state`  out  4  to DWR `tap_state`; 1149.1 state encoding.
- `ir`  out  4  to DWR `IR`.
- `dwr_tdi`  out  1  to DWR `TDI`.
- `dwr_tdo`  in  1  from DWR `wrapper_tdo`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Encodings:
  - TAP states: RTI 4'b1100, SELECT_DR 4'b0111, CAPTURE_DR 4'b0110, SHIFT_DR 4'b0010, EXIT1_DR 4'b0001, UPDATE_DR 4'b0101.
  - IR codes: EXTEST 4'b0000, INTEST 4'b0010, SAMPLE 4'b0100, BYPASS 4'b1111.
- FSM states: IDLE, SEL, CAP, SHIFT, EXIT1, UPD, RESP. `tap_state` is a register equal to the code of the current FSM state. IDLE and RESP both drive RTI.
- IDLE:
  - `cmd_ready`=1, `ir`=BYPASS, `dwr_tdi`=0.
  - On `cmd_valid`&&`cmd_ready`, latch `cmd_op` and `cmd_data` into internal registers.
  - Legal op: load `ir` with the matching code and go to SEL.
  - Illegal op (11): go directly to RESP with `rsp_err`=1, `rsp_data`=0, and no TAP activity.
- SEL → CAP: one cycle each. `ir` is held constant from SEL through UPD.
- SHIFT: exactly WIDTH cycles, counted 0..WIDTH-1.
  - In shift cycle k, `dwr_tdi` = latched `cmd_data[k]`.
  - On the rising edge that ends shift cycle k, sample `dwr_tdo` into `rsp_data[k]`.
  - The counter reaching WIDTH-1 moves the FSM to EXIT1.
- EXIT1 → UPD → RESP: one cycle each. UPD is the cycle in which the DWR commits its shift contents (EXTEST/INTEST only).
- RESP:
  - `rsp_valid`=1, `ir`=BYPASS, `tap_state`=RTI.
  - `rsp_data` and `rsp_err` are stable until handshake.
  - On `rsp_ready` go to IDLE. `rsp_ready` high in the same cycle `rsp_valid` first rises completes the handshake in one cycle.
- `cmd_valid` while busy is ignored. No queueing; the requester holds the command.
- `rsp_data` is cleared at command accept, so bits never carry stale data.

## Timing
- Accept edge = E0. `tap_state` values after each edge:
  - E1: SELECT_DR.
  - E2: CAPTURE_DR.
  - E3..E(WIDTH+2): SHIFT_DR.
  - E(WIDTH+3): EXIT1_DR.
  - E(WIDTH+4): UPDATE_DR.
  - E(WIDTH+5): RTI with `rsp_valid`=1. With WIDTH=8 this is E13.
- Minimum command-to-command spacing is WIDTH+7 cycles: accept, WIDTH+5 sequence cycles, one-cycle response, return to IDLE.
- Reset values, applied by synchronous reset when `TRST_N`=0 at an edge:
  - FSM=IDLE, `tap_state`=RTI, `ir`=BYPASS.
  - `dwr_tdi`=0, `cmd_ready`=1 (after reset release), `rsp_valid`=0, `rsp_err`=0, `rsp_data`=0, `busy`=0, counter=0.
- Reset mid-sequence: on the next edge the FSM is IDLE, no UPDATE_DR is ever issued for the aborted command, and no response is produced.

## Structure
- Package `dwr_pkg` holds the TAP state codes, the IR codes (EXTEST/INTEST/SAMPLE/BYPASS) and the `cmd_op` enum. The DWR and this block both import it.
- One natural sub-module: `dwr_shift_counter`, a loadable up-counter with a terminal-count flag at WIDTH-1. Everything else stays in one FSM module.

## Test plan
Bench: this block connected to a DWR (WIDTH=8) with `func_in`=8'h3C.
- Reset, then idle for 5 cycles → `tap_state`=4'b1100, `ir`=4'b1111, `cmd_ready`=1, `rsp_valid`=0 throughout.
- INTEST, `cmd_data`=8'hA5, `rsp_ready`=1 → `rsp_valid` at E13 with `rsp_data`=8'h3C, `rsp_err`=0; DWR `wrapper_out`=8'hA5 after the UPDATE_DR edge.
- SAMPLE, `cmd_data`=8'hFF, issued after the INTEST test → `rsp_data`=8'h3C; `wrapper_out` stays 8'hA5.
- EXTEST 8'h0F, then EXTEST 8'hF0 back-to-back with `rsp_ready` held low for 4 extra cycles → the second command is not accepted until the first response handshakes; `wrapper_out`=8'hF0 at the end.
- Illegal op 11 → `rsp_valid` one cycle after accept, `rsp_err`=1, `rsp_data`=0, `tap_state` never leaves RTI.
- `TRST_N` low during the 4th SHIFT_DR cycle of an INTEST 8'h55 → IDLE on the next edge, no UPDATE_DR seen, `wrapper_out` unchanged, no `rsp_valid`.
